anc_sample_sequencer: RTL and testbench
=======================================

Name: anc_sample_sequencer

Overview:
- Per-audio-sample scheduler for the ANC simulation loop.
- On each sample strobe it sequences three steps:
  - fire the ear-cup simulator with the new ambient sample and the current speaker sample;
  - fire the adaptive filter with the ambient reference and the returned feedback (error) sample;
  - publish the filter's new speaker sample.
- Sits between the sample-rate strobe generator, the cup simulator and the filter.
- Adds timeout and overrun supervision.

Parameters:
- TIMEOUT_CYCLES, 12'd2000: max cycles spent waiting for either done before abort.
- OVR_CNT_W, 8: width of the saturating overrun counter.

Ports:
- clk_in  input  1  system clock
- reset_n_in  input  1  asynchronous, active-low reset
- sample_strobe_in  input  1  one-cycle pulse, new ambient sample available
- ambient_sample_in  input  16 signed  ambient (reference) mic sample
- sim_ready_out  output  1  one-cycle start pulse to cup simulator
- sim_ambient_out  output  16 signed  latched ambient sample to simulator
- sim_speaker_out  output  16 signed  current speaker sample to simulator
- sim_done_in  input  1  simulator result valid
- sim_feedback_in  input  16 signed  simulator feedback sample
- filt_ready_out  output  1  one-cycle start pulse to adaptive filter
- filt_ref_out  output  16 signed  latched ambient sample to filter
- filt_error_out  output  16 signed  latched feedback sample to filter
- filt_done_in  input  1  filter result valid
- filt_sample_in  input  16 signed  filter's new speaker sample
- speaker_sample_out  output  16 signed  registered speaker sample
- sample_valid_out  output  1  one-cycle pulse, speaker_sample_out updated
- busy_out  output  1  high whenever state != IDLE
- timeout_err_out  output  1  sticky, set on any timeout
- overrun_count_out  output  OVR_CNT_W  saturating count of dropped strobes
- clear_err_in  input  1  synchronous clear of timeout_err_out and overrun_count_out

Behaviour:
- Reset (reset_n_in low, asynchronous):
  - state = IDLE;
  - all outputs 0, including all 16-bit registers and counters.
- All outputs are registered.
- FSM states: IDLE, SIM_START, SIM_WAIT, FILT_START, FILT_WAIT, OUTPUT.
- IDLE:
  - on sample_strobe_in, latch ambient_sample_in into the ambient register (drives sim_ambient_out and filt_ref_out) and go to SIM_START.
- SIM_START:
  - sim_ready_out = 1 for exactly this cycle;
  - sim_speaker_out holds speaker_sample_out;
  - clear wait counter; go to SIM_WAIT.
- SIM_WAIT:
  - if sim_done_in, latch sim_feedback_in into filt_error_out and go to FILT_START;
  - else if wait counter == TIMEOUT_CYCLES-1, set timeout_err_out and go to IDLE;
  - else increment the counter.
- FILT_START:
  - filt_ready_out = 1 for exactly this cycle;
  - clear counter; go to FILT_WAIT.
- FILT_WAIT:
  - if filt_done_in, latch filt_sample_in into speaker_sample_out and go to OUTPUT;
  - timeout handling same as SIM_WAIT.
- OUTPUT:
  - sample_valid_out = 1 for this cycle; go to IDLE.
- done inputs are honoured only in their WAIT state; done pulses in any other state are ignored.
- Minimum latency:
  - strobe sampled at edge 0, zero-wait dones;
  - sample_valid_out is high in cycle 5 (states, cycles 1-5: SIM_START, SIM_WAIT, FILT_START, FILT_WAIT, OUTPUT);
  - next strobe is accepted in cycle 6.
- On timeout, speaker_sample_out is unchanged and no sample_valid_out pulse is produced.
- Overrun: a strobe while state != IDLE is dropped and overrun_count_out increments. It saturates at all-ones and does not wrap.
- Strobe is accepted in IDLE only. A strobe in the same cycle that OUTPUT returns to IDLE counts as an overrun.
- clear_err_in:
  - clears timeout_err_out and overrun_count_out next edge;
  - if a timeout or overrun occurs in the same cycle, the set/increment wins (count becomes 1, error becomes 1).
- Reset asserted mid-sequence: immediate return to IDLE, all registers 0. Dones arriving after reset release are ignored.
- No arithmetic on samples; values pass through bit-exact.

Test Plan:
- Nominal flow:
  - Stimulus: ambient=16'sd1000; sim_done 1 cycle after sim_ready with feedback=16'sd500; filt_done 1 cycle after filt_ready with sample=-16'sd480.
  - Required: sim_ready in cycle 1 with sim_ambient=1000 and sim_speaker=0; filt_ready in cycle 3 with filt_ref=1000 and filt_error=500; sample_valid in cycle 5 with speaker=-480.
  - Second sample: sim_speaker_out = -480.
- Overrun:
  - Stimulus: 3 strobes while busy, then hold clear_err_in with a simultaneous 4th busy strobe.
  - Required: overrun_count_out = 3, then 1. The first sample completes normally.
- Overrun saturation:
  - Stimulus: 300 strobes while busy with OVR_CNT_W=8.
  - Required: overrun_count_out = 255.
- Timeout:
  - Stimulus: no sim_done, TIMEOUT_CYCLES=16.
  - Required: FSM returns to IDLE after 16 SIM_WAIT cycles; timeout_err_out = 1; no sample_valid_out; speaker_sample_out unchanged.
  - A later nominal sample completes and timeout_err_out stays 1 until clear_err_in.
- Stray dones:
  - Stimulus: sim_done_in/filt_done_in pulses in IDLE and FILT_WAIT (sim_done) with distinct data.
  - Required: no state change; filt_error_out and speaker_sample_out are not corrupted.
- Async reset in FILT_WAIT:
  - Required: all outputs 0 immediately without a clock edge; busy_out = 0.
  - After release, a fresh strobe produces a sample with latency 5.

Source files
------------

// File: rtl/anc_sample_sequencer.sv
// Per-sample scheduler for the ANC loop: runs cup simulator, then adaptive filter,
// then publishes the new speaker sample, with wait timeouts and strobe-overrun counting.
module anc_sample_sequencer #(
  parameter logic [11:0] TIMEOUT_CYCLES = 12'd2000,
  parameter int          OVR_CNT_W      = 8
) (
  input  logic                  clk_in,
  input  logic                  reset_n_in,
  input  logic                  sample_strobe_in,
  input  logic signed [15:0]    ambient_sample_in,
  output logic                  sim_ready_out,
  output logic signed [15:0]    sim_ambient_out,
  output logic signed [15:0]    sim_speaker_out,
  input  logic                  sim_done_in,
  input  logic signed [15:0]    sim_feedback_in,
  output logic                  filt_ready_out,
  output logic signed [15:0]    filt_ref_out,
  output logic signed [15:0]    filt_error_out,
  input  logic                  filt_done_in,
  input  logic signed [15:0]    filt_sample_in,
  output logic signed [15:0]    speaker_sample_out,
  output logic                  sample_valid_out,
  output logic                  busy_out,
  output logic                  timeout_err_out,
  output logic [OVR_CNT_W-1:0]  overrun_count_out,
  input  logic                  clear_err_in
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] SIM_START  = 3'd1;
  localparam logic [2:0] SIM_WAIT   = 3'd2;
  localparam logic [2:0] FILT_START = 3'd3;
  localparam logic [2:0] FILT_WAIT  = 3'd4;
  localparam logic [2:0] OUTPUT     = 3'd5;

  logic [2:0]         state;
  logic [2:0]         state_nx;
  logic [11:0]        wait_cnt;
  logic               timeout_hit;
  logic               overrun;
  logic signed [15:0] ambient_q;

  // Counter holds at all-ones instead of wrapping.
  function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign sim_ambient_out = ambient_q;
  assign filt_ref_out    = ambient_q;
  assign overrun         = sample_strobe_in && (state != IDLE);

  always_comb begin
    state_nx    = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE:       if (sample_strobe_in) state_nx = SIM_START;
      SIM_START:  state_nx = SIM_WAIT;
      SIM_WAIT: begin
        if (sim_done_in) begin
          state_nx = FILT_START;
        end else if (wait_cnt == TIMEOUT_CYCLES - 12'd1) begin
          timeout_hit = 1'b1;
          state_nx    = IDLE;
        end
      end
      FILT_START: state_nx = FILT_WAIT;
      FILT_WAIT: begin
        if (filt_done_in) begin
          state_nx = OUTPUT;
        end else if (wait_cnt == TIMEOUT_CYCLES - 12'd1) begin
          timeout_hit = 1'b1;
          state_nx    = IDLE;
        end
      end
      OUTPUT:     state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  // Strobes and status are registered from the next state so they line up with it.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state              <= IDLE;
      wait_cnt           <= '0;
      ambient_q          <= '0;
      sim_speaker_out    <= '0;
      filt_error_out     <= '0;
      speaker_sample_out <= '0;
      sim_ready_out      <= 1'b0;
      filt_ready_out     <= 1'b0;
      sample_valid_out   <= 1'b0;
      busy_out           <= 1'b0;
      timeout_err_out    <= 1'b0;
      overrun_count_out  <= '0;
    end else begin
      state            <= state_nx;
      busy_out         <= (state_nx != IDLE);
      sim_ready_out    <= (state_nx == SIM_START);
      filt_ready_out   <= (state_nx == FILT_START);
      sample_valid_out <= (state_nx == OUTPUT);

      if (state == IDLE && sample_strobe_in) begin
        ambient_q       <= ambient_sample_in;
        sim_speaker_out <= speaker_sample_out;
      end

      if (state == SIM_START || state == FILT_START) begin
        wait_cnt <= '0;
      end else if (state == SIM_WAIT || state == FILT_WAIT) begin
        wait_cnt <= wait_cnt + 12'd1;
      end

      if (state == SIM_WAIT && sim_done_in) begin
        filt_error_out <= sim_feedback_in;
      end
      if (state == FILT_WAIT && filt_done_in) begin
        speaker_sample_out <= filt_sample_in;
      end

      // A new event in the same cycle as a clear takes priority over the clear.
      if (timeout_hit) begin
        timeout_err_out <= 1'b1;
      end else if (clear_err_in) begin
        timeout_err_out <= 1'b0;
      end

      if (overrun) begin
        overrun_count_out <= clear_err_in ? {{(OVR_CNT_W-1){1'b0}}, 1'b1}
                                          : sat_inc(overrun_count_out);
      end else if (clear_err_in) begin
        overrun_count_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_anc_sample_sequencer.sv
// Scoreboard bench for anc_sample_sequencer: drives the simulator/filter handshakes
// cycle by cycle and checks latency, data pass-through, timeout, overrun and reset.
module tb_anc_sample_sequencer;

  logic               clk_in;
  logic               reset_n_in;
  logic               sample_strobe_in;
  logic signed [15:0] ambient_sample_in;
  logic               sim_ready_out;
  logic signed [15:0] sim_ambient_out;
  logic signed [15:0] sim_speaker_out;
  logic               sim_done_in;
  logic signed [15:0] sim_feedback_in;
  logic               filt_ready_out;
  logic signed [15:0] filt_ref_out;
  logic signed [15:0] filt_error_out;
  logic               filt_done_in;
  logic signed [15:0] filt_sample_in;
  logic signed [15:0] speaker_sample_out;
  logic               sample_valid_out;
  logic               busy_out;
  logic               timeout_err_out;
  logic [7:0]         overrun_count_out;
  logic               clear_err_in;

  anc_sample_sequencer #(.TIMEOUT_CYCLES(12'd16), .OVR_CNT_W(8)) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in),
    .sample_strobe_in(sample_strobe_in), .ambient_sample_in(ambient_sample_in),
    .sim_ready_out(sim_ready_out), .sim_ambient_out(sim_ambient_out),
    .sim_speaker_out(sim_speaker_out), .sim_done_in(sim_done_in),
    .sim_feedback_in(sim_feedback_in), .filt_ready_out(filt_ready_out),
    .filt_ref_out(filt_ref_out), .filt_error_out(filt_error_out),
    .filt_done_in(filt_done_in), .filt_sample_in(filt_sample_in),
    .speaker_sample_out(speaker_sample_out), .sample_valid_out(sample_valid_out),
    .busy_out(busy_out), .timeout_err_out(timeout_err_out),
    .overrun_count_out(overrun_count_out), .clear_err_in(clear_err_in)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;

  logic signed [15:0] exp_q[$];
  logic signed [15:0] log_spk  [0:63];
  logic signed [15:0] log_err  [0:63];
  logic               log_busy [0:63];
  logic               log_terr [0:63];
  logic [7:0]         log_ovr  [0:63];
  int                 sim_cyc, filt_cyc, valid_cyc;
  logic signed [15:0] o_sim_amb, o_sim_spk, o_ref, o_err, o_spk, exp_v;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Cycle 0 raises the strobe; cycle k is observed 1 time unit after the k-th edge.
  task automatic drive_sample(input logic signed [15:0] amb, fb, fs,
                              input int sim_dly, filt_dly, max_cyc,
                              input logic [63:0] stb_mask, clr_mask, sim_stray, filt_stray);
    int  sim_cnt, filt_cnt, cyc;
    bit  fin;
    sim_cnt = 0; filt_cnt = 0; cyc = 0; fin = 0;
    sim_cyc = -1; filt_cyc = -1; valid_cyc = -1;
    while (!fin) begin
      log_spk[cyc]  = speaker_sample_out;
      log_err[cyc]  = filt_error_out;
      log_busy[cyc] = busy_out;
      log_terr[cyc] = timeout_err_out;
      log_ovr[cyc]  = overrun_count_out;
      sample_strobe_in  = (cyc == 0) || stb_mask[cyc];
      ambient_sample_in = (cyc == 0) ? amb : 16'sh5a5a;
      clear_err_in      = clr_mask[cyc];
      sim_done_in       = sim_stray[cyc];
      sim_feedback_in   = 16'sd4321;
      if (sim_cnt == 1) begin
        sim_done_in     = 1'b1;
        sim_feedback_in = fb;
      end
      if (sim_cnt > 0) sim_cnt--;
      if (sim_ready_out && sim_cyc < 0) begin
        sim_cyc   = cyc;
        o_sim_amb = sim_ambient_out;
        o_sim_spk = sim_speaker_out;
        sim_cnt   = sim_dly;
      end
      filt_done_in   = filt_stray[cyc];
      filt_sample_in = 16'sd999;
      if (filt_cnt == 1) begin
        filt_done_in   = 1'b1;
        filt_sample_in = fs;
        exp_q.push_back(fs);
      end
      if (filt_cnt > 0) filt_cnt--;
      if (filt_ready_out && filt_cyc < 0) begin
        filt_cyc = cyc;
        o_ref    = filt_ref_out;
        o_err    = filt_error_out;
        filt_cnt = filt_dly;
      end
      if (sample_valid_out) begin
        valid_cyc = cyc;
        o_spk     = speaker_sample_out;
        fin       = 1;
      end
      if (cyc >= max_cyc) fin = 1;
      if (!fin) begin
        step();
        cyc++;
      end
    end
    if (valid_cyc >= 0) step();
    sample_strobe_in = 1'b0;
    clear_err_in     = 1'b0;
    sim_done_in      = 1'b0;
    filt_done_in     = 1'b0;
  endtask

  task automatic test_reset();
    reset_n_in = 1'b0;
    sample_strobe_in = 0; ambient_sample_in = 0; sim_done_in = 0; sim_feedback_in = 0;
    filt_done_in = 0; filt_sample_in = 0; clear_err_in = 0;
    #2;
    n_checks++;
    if ({sim_ready_out, filt_ready_out, sample_valid_out, busy_out, timeout_err_out} !== 5'b0)
      $display("FAIL reset_ctrl: got %b expected 00000",
               {sim_ready_out, filt_ready_out, sample_valid_out, busy_out, timeout_err_out});
    else n_pass++;
    n_checks++;
    if ({sim_ambient_out, sim_speaker_out, filt_ref_out, filt_error_out, speaker_sample_out,
         overrun_count_out} !== 88'd0)
      $display("FAIL reset_data: some data register nonzero, speaker=%0d ovr=%0d",
               speaker_sample_out, overrun_count_out);
    else n_pass++;
    step(); step();
    reset_n_in = 1'b1;
    step();
  endtask

  task automatic check_pop(input string name);
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: sample_valid with empty scoreboard, speaker=%0d", name, o_spk);
    end else begin
      exp_v = exp_q.pop_front();
      if (o_spk !== exp_v) $display("FAIL %s: speaker got %0d expected %0d", name, o_spk, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_nominal();
    drive_sample(16'sd1000, 16'sd500, -16'sd480, 1, 1, 40, 64'h0, 64'h0, 64'h0, 64'h0);
    n_checks++;
    if (sim_cyc !== 1 || o_sim_amb !== 16'sd1000 || o_sim_spk !== 16'sd0)
      $display("FAIL nom_sim: cyc=%0d amb=%0d spk=%0d expected cyc=1 amb=1000 spk=0",
               sim_cyc, o_sim_amb, o_sim_spk);
    else n_pass++;
    n_checks++;
    if (filt_cyc !== 3 || o_ref !== 16'sd1000 || o_err !== 16'sd500)
      $display("FAIL nom_filt: cyc=%0d ref=%0d err=%0d expected cyc=3 ref=1000 err=500",
               filt_cyc, o_ref, o_err);
    else n_pass++;
    n_checks++;
    if (valid_cyc !== 5) $display("FAIL nom_latency: valid cycle %0d expected 5", valid_cyc);
    else n_pass++;
    check_pop("nom_speaker");
    n_checks++;
    if (sample_valid_out !== 1'b0 || busy_out !== 1'b0)
      $display("FAIL nom_idle: valid=%b busy=%b expected 0 0", sample_valid_out, busy_out);
    else n_pass++;
    drive_sample(-16'sd2000, -16'sd32768, 16'sd32767, 1, 1, 40, 64'h0, 64'h0, 64'h0, 64'h0);
    n_checks++;
    if (o_sim_spk !== -16'sd480 || o_sim_amb !== -16'sd2000)
      $display("FAIL nom2_sim: spk=%0d amb=%0d expected -480 -2000", o_sim_spk, o_sim_amb);
    else n_pass++;
    n_checks++;
    if (o_err !== -16'sd32768) $display("FAIL nom2_err: got %0d expected -32768", o_err);
    else n_pass++;
    check_pop("nom2_speaker");
  endtask

  task automatic test_back_to_back();
    drive_sample(16'sd7, 16'sd8, 16'sd9, 1, 1, 40, 64'h0, 64'h0, 64'h0, 64'h0);
    check_pop("b2b_first");
    drive_sample(16'sd70, 16'sd80, -16'sd90, 1, 1, 40, 64'h0, 64'h0, 64'h0, 64'h0);
    n_checks++;
    if (valid_cyc !== 5 || o_sim_spk !== 16'sd9)
      $display("FAIL b2b_second: valid cycle %0d sim_spk %0d expected 5 9", valid_cyc, o_sim_spk);
    else n_pass++;
    check_pop("b2b_second_speaker");
    n_checks++;
    if (overrun_count_out !== 8'd0) $display("FAIL b2b_ovr: got %0d expected 0", overrun_count_out);
    else n_pass++;
  endtask

  task automatic test_overrun();
    drive_sample(16'sd2500, 16'sd10, 16'sd20, 1, 1, 40, 64'h3e, 64'h10, 64'h0, 64'h0);
    n_checks++;
    if (log_ovr[4] !== 8'd3) $display("FAIL ovr_three: got %0d expected 3", log_ovr[4]);
    else n_pass++;
    n_checks++;
    if (log_ovr[5] !== 8'd1) $display("FAIL ovr_clear_win: got %0d expected 1", log_ovr[5]);
    else n_pass++;
    n_checks++;
    if (valid_cyc !== 5 || o_ref !== 16'sd2500)
      $display("FAIL ovr_sample: valid cycle %0d ref %0d expected 5 2500", valid_cyc, o_ref);
    else n_pass++;
    check_pop("ovr_speaker");
    n_checks++;
    if (overrun_count_out !== 8'd2 || busy_out !== 1'b0)
      $display("FAIL ovr_output_strobe: ovr=%0d busy=%b expected 2 0", overrun_count_out, busy_out);
    else n_pass++;
    clear_err_in = 1'b1; step(); clear_err_in = 1'b0;
    n_checks++;
    if (overrun_count_out !== 8'd0) $display("FAIL ovr_cleared: got %0d expected 0", overrun_count_out);
    else n_pass++;
  endtask

  task automatic test_stray_dones();
    sim_done_in = 1'b1; sim_feedback_in = 16'sd1234;
    filt_done_in = 1'b1; filt_sample_in = 16'sd777;
    step();
    sim_done_in = 1'b0; filt_done_in = 1'b0;
    n_checks++;
    if (busy_out !== 1'b0 || filt_error_out !== 16'sd10 || speaker_sample_out !== 16'sd20)
      $display("FAIL stray_idle: busy=%b err=%0d spk=%0d expected 0 10 20",
               busy_out, filt_error_out, speaker_sample_out);
    else n_pass++;
    drive_sample(16'sd300, -16'sd7, -16'sd9, 1, 3, 40, 64'h0, 64'h0, 64'h10, 64'h4);
    n_checks++;
    if (o_err !== -16'sd7 || log_err[5] !== -16'sd7 || log_busy[5] !== 1'b1)
      $display("FAIL stray_filt_wait: err=%0d after=%0d busy=%b expected -7 -7 1",
               o_err, log_err[5], log_busy[5]);
    else n_pass++;
    n_checks++;
    if (valid_cyc !== 7) $display("FAIL stray_latency: valid cycle %0d expected 7", valid_cyc);
    else n_pass++;
    check_pop("stray_speaker");
  endtask

  task automatic test_timeout();
    drive_sample(16'sd55, 16'sd66, 16'sd77, 0, 1, 22, 64'h0, 64'h0, 64'h0, 64'h0);
    n_checks++;
    if (log_busy[17] !== 1'b1 || log_busy[18] !== 1'b0)
      $display("FAIL to_idle: busy c17=%b c18=%b expected 1 0", log_busy[17], log_busy[18]);
    else n_pass++;
    n_checks++;
    if (log_terr[17] !== 1'b0 || log_terr[18] !== 1'b1)
      $display("FAIL to_err: c17=%b c18=%b expected 0 1", log_terr[17], log_terr[18]);
    else n_pass++;
    n_checks++;
    if (valid_cyc !== -1 || speaker_sample_out !== -16'sd9)
      $display("FAIL to_no_output: valid cycle %0d spk %0d expected -1 -9",
               valid_cyc, speaker_sample_out);
    else n_pass++;
    drive_sample(16'sd1, 16'sd2, 16'sd3, 1, 1, 40, 64'h0, 64'h0, 64'h0, 64'h0);
    check_pop("to_recover_speaker");
    n_checks++;
    if (timeout_err_out !== 1'b1) $display("FAIL to_sticky: got %b expected 1", timeout_err_out);
    else n_pass++;
    clear_err_in = 1'b1; step(); clear_err_in = 1'b0;
    n_checks++;
    if (timeout_err_out !== 1'b0) $display("FAIL to_clear: got %b expected 0", timeout_err_out);
    else n_pass++;
  endtask

  task automatic test_saturation();
    sample_strobe_in = 1'b1;
    ambient_sample_in = 16'sd0;
    repeat (340) step();
    sample_strobe_in = 1'b0;
    for (int i = 0; i < 40 && busy_out; i++) step();
    n_checks++;
    if (busy_out !== 1'b0) $display("FAIL sat_idle: busy=%b expected 0 after bounded wait", busy_out);
    else n_pass++;
    n_checks++;
    if (overrun_count_out !== 8'd255) $display("FAIL sat_count: got %0d expected 255", overrun_count_out);
    else n_pass++;
    clear_err_in = 1'b1; step(); clear_err_in = 1'b0;
  endtask

  task automatic test_async_reset();
    drive_sample(16'sd111, 16'sd222, 16'sd333, 1, 0, 4, 64'h0, 64'h0, 64'h0, 64'h0);
    n_checks++;
    if (busy_out !== 1'b1 || filt_error_out !== 16'sd222)
      $display("FAIL ar_pre: busy=%b err=%0d expected 1 222", busy_out, filt_error_out);
    else n_pass++;
    #1 reset_n_in = 1'b0;
    #1;
    n_checks++;
    if ({busy_out, sim_ready_out, filt_ready_out, sample_valid_out, timeout_err_out} !== 5'b0 ||
        {sim_ambient_out, sim_speaker_out, filt_ref_out, filt_error_out, speaker_sample_out,
         overrun_count_out} !== 88'd0)
      $display("FAIL ar_immediate: busy=%b err=%0d spk=%0d ref=%0d expected all 0",
               busy_out, filt_error_out, speaker_sample_out, filt_ref_out);
    else n_pass++;
    step(); step();
    reset_n_in = 1'b1;
    filt_done_in = 1'b1; filt_sample_in = 16'sd777;
    sim_done_in = 1'b1; sim_feedback_in = 16'sd888;
    step();
    filt_done_in = 1'b0; sim_done_in = 1'b0;
    n_checks++;
    if (busy_out !== 1'b0 || speaker_sample_out !== 16'sd0 || filt_error_out !== 16'sd0)
      $display("FAIL ar_late_done: busy=%b spk=%0d err=%0d expected 0 0 0",
               busy_out, speaker_sample_out, filt_error_out);
    else n_pass++;
    drive_sample(16'sd1000, 16'sd500, -16'sd480, 1, 1, 40, 64'h0, 64'h0, 64'h0, 64'h0);
    n_checks++;
    if (valid_cyc !== 5 || o_sim_spk !== 16'sd0)
      $display("FAIL ar_fresh: valid cycle %0d sim_spk %0d expected 5 0", valid_cyc, o_sim_spk);
    else n_pass++;
    check_pop("ar_fresh_speaker");
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sb_empty: %0d entries left expected 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_overrun();
    test_stray_dones();
    test_timeout();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
